// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller and its ALU decoder.
// Holds opcode/funct constants, ALU control codes, mux encodings, the FSM state
// enum, the per-state control bundle and small decode helpers.
package mips_pkg;

  localparam int unsigned NumStates = 13;
  localparam int unsigned StateW    = $clog2(NumStates);
  localparam int unsigned AluCtrlW  = 4;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // R-type funct (IR[5:0])
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  // ALU operation codes
  localparam logic [AluCtrlW-1:0] AluAnd = 4'b0000;
  localparam logic [AluCtrlW-1:0] AluOr  = 4'b0001;
  localparam logic [AluCtrlW-1:0] AluAdd = 4'b0010;
  localparam logic [AluCtrlW-1:0] AluSub = 4'b0110;
  localparam logic [AluCtrlW-1:0] AluSlt = 4'b0111;

  // ALU B operand select
  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // Next-PC select
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  // ALU operation class handed to the ALU decoder. None yields an all-zero code.
  typedef enum logic [1:0] {
    AluOpNone,
    AluOpAdd,
    AluOpSub,
    AluOpFunct
  } alu_op_e;

  // Encodings 0..12 in declaration order; 13..15 are unreachable.
  typedef enum logic [StateW-1:0] {
    StRst,
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExec,
    StAluWb,
    StBranch,
    StAddiEx,
    StAddiWb,
    StJump
  } state_e;

  // Moore control bundle. *_rdy fields only take effect when memory is ready;
  // branch is resolved against the zero flag outside the register.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_rdy;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write_rdy;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_e    alu_op;
    logic [1:0] pc_src;
    logic       done;
    logic       done_rdy;
  } ctl_t;

  function automatic logic funct_legal(input logic [5:0] fn);
    return fn inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt};
  endfunction

  function automatic logic opcode_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == OpRtype) return funct_legal(fn);
    return op inside {OpLw, OpSw, OpBeq, OpBne, OpAddi, OpJ};
  endfunction

  function automatic ctl_t state_ctl(input state_e st);
    ctl_t c;
    c = '0;
    case (st)
      StFetch: begin
        c.mem_read     = 1'b1;
        c.ir_write_rdy = 1'b1;
        c.pc_write_rdy = 1'b1;
        c.alu_src_b    = SrcBFour;
        c.alu_op       = AluOpAdd;
        c.pc_src       = PcSrcAlu;
      end
      StDecode: begin
        c.alu_src_b = SrcBImmSh;
        c.alu_op    = AluOpAdd;
      end
      StMemAdr, StAddiEx: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBImm;
        c.alu_op    = AluOpAdd;
      end
      StMemRd: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      StMemWb: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.done       = 1'b1;
      end
      StMemWr: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        c.done_rdy  = 1'b1;
      end
      StExec: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBReg;
        c.alu_op    = AluOpFunct;
      end
      StAluWb: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.done      = 1'b1;
      end
      StBranch: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBReg;
        c.alu_op    = AluOpSub;
        c.pc_src    = PcSrcAluOut;
        c.branch    = 1'b1;
        c.done      = 1'b1;
      end
      StAddiWb: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      StJump: begin
        c.pc_src   = PcSrcJump;
        c.pc_write = 1'b1;
        c.done     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control decoder, shared with the single-cycle CPU.
// Ports:
//   i_alu_op   - ALU operation class (alu_op_e encoding)
//   i_funct    - R-type funct field
//   o_alu_ctrl - ALU operation code
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0]          i_alu_op,
  input  logic [5:0]          i_funct,
  output logic [AluCtrlW-1:0] o_alu_ctrl
);

  always_comb begin
    o_alu_ctrl = '0;
    case (alu_op_e'(i_alu_op))
      AluOpAdd: o_alu_ctrl = AluAdd;
      AluOpSub: o_alu_ctrl = AluSub;
      AluOpFunct: begin
        case (i_funct)
          FnAdd:   o_alu_ctrl = AluAdd;
          FnSub:   o_alu_ctrl = AluSub;
          FnAnd:   o_alu_ctrl = AluAnd;
          FnOr:    o_alu_ctrl = AluOr;
          FnSlt:   o_alu_ctrl = AluSlt;
          default: o_alu_ctrl = AluAdd;
        endcase
      end
      default: o_alu_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Ports:
//   i_clk, i_arst         - clock, asynchronous active-high reset
//   i_opcode, i_funct     - IR fields, sampled in DECODE
//   i_zero                - ALU zero flag (branch resolution)
//   i_mem_ready           - memory completes its access this cycle
//   o_pc_write .. o_pc_src - datapath enables and mux selects
//   o_instr_done          - pulse on the last cycle of each instruction
//   o_illegal             - pulse in DECODE on an unsupported instruction
//   o_state               - current state encoding
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_arst,
  input  logic [5:0]          i_opcode,
  input  logic [5:0]          i_funct,
  input  logic                i_zero,
  input  logic                i_mem_ready,
  output logic                o_pc_write,
  output logic                o_iord,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_ir_write,
  output logic                o_reg_dst,
  output logic                o_mem_to_reg,
  output logic                o_reg_write,
  output logic                o_alu_src_a,
  output logic [1:0]          o_alu_src_b,
  output logic [AluCtrlW-1:0] o_alu_ctrl,
  output logic [1:0]          o_pc_src,
  output logic                o_instr_done,
  output logic                o_illegal,
  output logic [StateW-1:0]   o_state
);

  state_e     state_q, state_d;
  logic [5:0] op_q, funct_q;
  ctl_t       ctl_q;
  logic       decode_illegal;
  logic       branch_taken;

  assign decode_illegal = (state_q == StDecode) && !opcode_legal(i_opcode, i_funct);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRst:    state_d = StFetch;
      StFetch:  state_d = i_mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (i_opcode)
          OpRtype:     state_d = funct_legal(i_funct) ? StExec : StFetch;
          OpLw, OpSw:  state_d = StMemAdr;
          OpBeq, OpBne: state_d = StBranch;
          OpAddi:      state_d = StAddiEx;
          OpJ:         state_d = StJump;
          default:     state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (op_q == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = i_mem_ready ? StMemWb : StMemRd;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = i_mem_ready ? StFetch : StMemWr;
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StJump:   state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Control bundle is registered from the next state so it lines up with state_q.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= StRst;
      ctl_q   <= '0;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= state_ctl(state_d);
      if (state_q == StDecode) begin
        op_q    <= i_opcode;
        funct_q <= i_funct;
      end
    end
  end

  assign branch_taken = (op_q == OpBeq) ? i_zero : !i_zero;

  assign o_pc_write   = ctl_q.pc_write | (ctl_q.pc_write_rdy & i_mem_ready) |
                        (ctl_q.branch & branch_taken);
  assign o_ir_write   = ctl_q.ir_write_rdy & i_mem_ready;
  assign o_instr_done = ctl_q.done | (ctl_q.done_rdy & i_mem_ready) | decode_illegal;
  assign o_illegal    = decode_illegal;
  assign o_iord       = ctl_q.iord;
  assign o_mem_read   = ctl_q.mem_read;
  assign o_mem_write  = ctl_q.mem_write;
  assign o_reg_dst    = ctl_q.reg_dst;
  assign o_mem_to_reg = ctl_q.mem_to_reg;
  assign o_reg_write  = ctl_q.reg_write;
  assign o_alu_src_a  = ctl_q.alu_src_a;
  assign o_alu_src_b  = ctl_q.alu_src_b;
  assign o_pc_src     = ctl_q.pc_src;
  assign o_state      = state_q;

  mips_alu_decoder u_alu_decoder (
    .i_alu_op   (ctl_q.alu_op),
    .i_funct    (funct_q),
    .o_alu_ctrl (o_alu_ctrl)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, instr_done, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_ctrl, state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .i_clk        (clk),
    .i_arst       (arst),
    .i_opcode     (opcode),
    .i_funct      (funct),
    .i_zero       (zero),
    .i_mem_ready  (mem_ready),
    .o_pc_write   (pc_write),
    .o_iord       (iord),
    .o_mem_read   (mem_read),
    .o_mem_write  (mem_write),
    .o_ir_write   (ir_write),
    .o_reg_dst    (reg_dst),
    .o_mem_to_reg (mem_to_reg),
    .o_reg_write  (reg_write),
    .o_alu_src_a  (alu_src_a),
    .o_alu_src_b  (alu_src_b),
    .o_alu_ctrl   (alu_ctrl),
    .o_pc_src     (pc_src),
    .o_instr_done (instr_done),
    .o_illegal    (illegal),
    .o_state      (state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic pcw, mr, mw, irw, rw, done, ill;
    logic iord, rdst, m2r, srca;
    logic [1:0] srcb;
    logic [3:0] alu;
    logic [1:0] pcs;
  } obs_t;

  obs_t obs;
  assign obs = {state, pc_write, mem_read, mem_write, ir_write, reg_write, instr_done, illegal,
                iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src};

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010;
  logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == R) return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    return op inside {LW, SW, BEQ, BNE, ADDI, J};
  endfunction

  function automatic logic [3:0] alu_of_funct(input logic [5:0] fn);
    case (fn)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  // Expected outputs for one cycle in state st; c marks which fields are defined there.
  task automatic expect_of(input int st, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic rdy, output obs_t e, output obs_t c);
    e = '0;
    c = '0;
    c.st = '1;
    {c.pcw, c.mr, c.mw, c.irw, c.rw, c.done, c.ill} = '1;
    e.st = 4'(st);
    case (st)
      1: begin
        e.mr = 1; e.irw = rdy; e.pcw = rdy; e.srcb = 2'b01; e.alu = 4'b0010;
        {c.iord, c.srca, c.srcb, c.alu, c.pcs} = '1;
      end
      2: begin
        e.srcb = 2'b11; e.alu = 4'b0010; {c.srca, c.srcb, c.alu} = '1;
        if (!is_legal(op, fn)) begin e.ill = 1; e.done = 1; end
      end
      3, 10: begin
        e.srca = 1; e.srcb = 2'b10; e.alu = 4'b0010; {c.srca, c.srcb, c.alu} = '1;
      end
      4: begin e.mr = 1; e.iord = 1; c.iord = 1; end
      5: begin e.rw = 1; e.m2r = 1; e.done = 1; {c.rdst, c.m2r} = '1; end
      6: begin e.mw = 1; e.iord = 1; e.done = rdy; c.iord = 1; end
      7: begin e.srca = 1; e.alu = alu_of_funct(fn); {c.srca, c.srcb, c.alu} = '1; end
      8: begin e.rw = 1; e.rdst = 1; e.done = 1; {c.rdst, c.m2r} = '1; end
      9: begin
        e.srca = 1; e.alu = 4'b0110; e.pcs = 2'b01; e.done = 1;
        e.pcw = (op == BEQ) ? z : !z;
        {c.srca, c.srcb, c.alu, c.pcs} = '1;
      end
      11: begin e.rw = 1; e.done = 1; {c.rdst, c.m2r} = '1; end
      12: begin e.pcs = 2'b10; e.pcw = 1; e.done = 1; c.pcs = 1; end
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input obs_t e, input obs_t c);
    checks++;
    assert (((obs ^ e) & c) === '0)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (care %h)", tag, obs, e, c);
    end
  endtask

  // One clock cycle: IR fields are only meaningful in DECODE, so drive noise elsewhere.
  task automatic step(input string tag, input int st, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic rdy, output logic done_seen);
    obs_t e, c;
    opcode    = (st == 2) ? op : 6'($urandom);
    funct     = (st == 2) ? fn : 6'($urandom);
    zero      = z;
    mem_ready = rdy;
    #2;
    expect_of(st, op, fn, z, rdy, e, c);
    check(tag, e, c);
    done_seen = (instr_done === 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int fetch_stall, input int mem_stall, input logic zbr);
    int seq[$];
    int cyc = 0;
    int done_at = -1;
    int latency;
    logic d;
    if (!is_legal(op, fn)) seq = '{1, 2};
    else case (op)
      R:        seq = '{1, 2, 7, 8};
      LW:       seq = '{1, 2, 3, 4, 5};
      SW:       seq = '{1, 2, 3, 6};
      BEQ, BNE: seq = '{1, 2, 9};
      ADDI:     seq = '{1, 2, 10, 11};
      default:  seq = '{1, 2, 12};
    endcase
    latency = seq.size() + fetch_stall + ((op inside {LW, SW} && is_legal(op, fn)) ? mem_stall : 0);
    foreach (seq[i]) begin
      int st = seq[i];
      bit memph = (st == 1) || (st == 4) || (st == 6);
      int stalls = (st == 1) ? fetch_stall : (memph ? mem_stall : 0);
      for (int k = 0; k <= stalls; k++) begin
        logic rdy = memph ? (k == stalls) : 1'($urandom);
        logic z = (st == 9) ? zbr : 1'($urandom);
        step(tag, st, op, fn, z, rdy, d);
        if (d && done_at < 0) done_at = cyc;
        cyc++;
      end
    end
    checks++;
    assert (done_at === latency - 1)
    else begin
      errors++;
      $error("FAIL %s latency: done at cycle %0d, expected %0d", tag, done_at + 1, latency);
    end
  endtask

  task automatic check_reset_zero(input string tag);
    obs_t e, c;
    e = '0;
    c = '1;
    check(tag, e, c);
  endtask

  initial begin
    logic d;
    logic [5:0] op, fn;
    int kind;

    // Power-on reset, memory ready high to show nothing leaks through.
    mem_ready = 1'b1;
    zero = 1'b1;
    #3;
    check_reset_zero("reset_hold");
    @(posedge clk);
    #1;
    check_reset_zero("reset_hold_edge");
    arst = 1'b0;
    #2;
    check_reset_zero("reset_released_rst");
    @(posedge clk);
    #1;

    run_instr("add", R, 6'b100000, 0, 0, 1'b0);
    run_instr("lw_stall2", LW, 6'($urandom), 0, 2, 1'b0);
    run_instr("beq_z1", BEQ, 6'($urandom), 0, 0, 1'b1);
    run_instr("beq_z0", BEQ, 6'($urandom), 0, 0, 1'b0);
    run_instr("bne_z1", BNE, 6'($urandom), 0, 0, 1'b1);
    run_instr("bne_z0", BNE, 6'($urandom), 0, 0, 1'b0);
    run_instr("j", J, 6'($urandom), 0, 0, 1'b0);
    run_instr("illegal_op", 6'b111111, 6'($urandom), 0, 0, 1'b0);
    run_instr("illegal_funct", R, 6'b000111, 1, 0, 1'b0);
    run_instr("sw_stall", SW, 6'($urandom), 1, 1, 1'b0);
    run_instr("addi", ADDI, 6'($urandom), 0, 0, 1'b0);
    run_instr("slt", R, 6'b101010, 2, 0, 1'b0);

    // Reset in the middle of a stalled lw read.
    step("mid_fetch", 1, LW, 6'h00, 1'b0, 1'b1, d);
    step("mid_decode", 2, LW, 6'h00, 1'b0, 1'b0, d);
    step("mid_memadr", 3, LW, 6'h00, 1'b0, 1'b0, d);
    step("mid_memrd", 4, LW, 6'h00, 1'b0, 1'b0, d);
    mem_ready = 1'b1;
    arst = 1'b1;
    #2;
    check_reset_zero("reset_mid_memrd");
    @(posedge clk);
    #1;
    check_reset_zero("reset_mid_memrd_edge");
    arst = 1'b0;
    #2;
    check_reset_zero("reset_mid_released");
    @(posedge clk);
    #1;
    step("fetch_after_reset", 1, J, 6'h00, 1'b0, 1'b0, d);
    run_instr("j_after_reset", J, 6'($urandom), 0, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      kind = int'($urandom_range(0, 7));
      fn = 6'($urandom);
      case (kind)
        0: begin op = R; fn = legal_fn[$urandom_range(0, 4)]; end
        1: op = LW;
        2: op = SW;
        3: op = BEQ;
        4: op = BNE;
        5: op = ADDI;
        6: op = J;
        default: begin
          op = 6'($urandom);
          while (is_legal(op, fn)) op = 6'($urandom);
        end
      endcase
      run_instr("random", op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
